// File: rtl/lab_cpu_pkg.sv
// Shared widths and opcode constants for the lab CPU pipeline.
// Latency: n/a (package only).
// Backpressure: n/a.
package lab_cpu_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int OPC_WIDTH_DEF  = 6;

  localparam logic [OPC_WIDTH_DEF-1:0] OPC_NOP = 6'd0;
  localparam logic [OPC_WIDTH_DEF-1:0] OPC_ADD = 6'd1;
  localparam logic [OPC_WIDTH_DEF-1:0] OPC_SUB = 6'd2;
  localparam logic [OPC_WIDTH_DEF-1:0] OPC_AND = 6'd3;
  localparam logic [OPC_WIDTH_DEF-1:0] OPC_OR  = 6'd4;
  localparam logic [OPC_WIDTH_DEF-1:0] OPC_XOR = 6'd5;
  localparam logic [OPC_WIDTH_DEF-1:0] OPC_LD  = 6'd6;
  localparam logic [OPC_WIDTH_DEF-1:0] OPC_ST  = 6'd7;

endpackage

// File: rtl/operand_fetch_fifo2.sv
// Two-entry output buffer for fetched instructions (optional OPERAND_FETCH_BYPASS_EN: per-entry writeback snoop).
// Latency: a push into an empty buffer is visible on the head in the same cycle; otherwise head is registered.
// Backpressure: caller never pushes when full; pop is ignored unless the head is valid.
module operand_fetch_fifo2
  import lab_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int OPC_WIDTH  = OPC_WIDTH_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  push,
  input  logic [OPC_WIDTH-1:0]  push_opc,
  input  logic [ADDR_WIDTH-1:0] push_dest,
  input  logic [DATA_WIDTH-1:0] push_op0,
  input  logic [DATA_WIDTH-1:0] push_op1,
`ifdef OPERAND_FETCH_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0] push_src0,
  input  logic [ADDR_WIDTH-1:0] push_src1,
  input  logic                  snoop_vld,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  input  logic [DATA_WIDTH-1:0] snoop_dat,
`endif
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic                  head_vld,
  output logic [OPC_WIDTH-1:0]  head_opc,
  output logic [ADDR_WIDTH-1:0] head_dest,
  output logic [DATA_WIDTH-1:0] head_op0,
  output logic [DATA_WIDTH-1:0] head_op1
);

  typedef struct packed {
    logic [OPC_WIDTH-1:0]  opc;
    logic [ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] op0;
    logic [DATA_WIDTH-1:0] op1;
`ifdef OPERAND_FETCH_BYPASS_EN
    logic [ADDR_WIDTH-1:0] src0;
    logic [ADDR_WIDTH-1:0] src1;
`endif
  } entry_t;

  entry_t     mem [2];
  entry_t     push_ent;
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       do_pop;
  logic       stored_pop;
  logic       do_write;

  assign push_ent.opc  = push_opc;
  assign push_ent.dest = push_dest;
  assign push_ent.op0  = push_op0;
  assign push_ent.op1  = push_op1;
`ifdef OPERAND_FETCH_BYPASS_EN
  assign push_ent.src0 = push_src0;
  assign push_ent.src1 = push_src1;
`endif

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign head_vld = !empty || push;

  // When empty the incoming entry is the head; it is stored only if not consumed this cycle.
  assign head_opc  = empty ? push_opc  : mem[rd_ptr].opc;
  assign head_dest = empty ? push_dest : mem[rd_ptr].dest;
  assign head_op0  = empty ? push_op0  : mem[rd_ptr].op0;
  assign head_op1  = empty ? push_op1  : mem[rd_ptr].op1;

  assign do_pop     = pop && head_vld;
  assign stored_pop = do_pop && !empty;
  assign do_write   = push && !(empty && do_pop);

  // Storage, pointers and occupancy; snooped operands refresh every cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else begin
`ifdef OPERAND_FETCH_BYPASS_EN
      for (int i = 0; i < 2; i++) begin
        if (snoop_vld && (mem[i].src0 == snoop_addr)) mem[i].op0 <= snoop_dat;
        if (snoop_vld && (mem[i].src1 == snoop_addr)) mem[i].op1 <= snoop_dat;
      end
`endif
      if (do_write) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= !wr_ptr;
      end
      if (stored_pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({do_write, stored_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: issues register reads, joins returned data with the instruction (OPERAND_FETCH_BYPASS_EN: writeback snoop).
// Latency: accept in N -> oValid in N+1 through the empty-buffer bypass; registered buffer head afterwards.
// Backpressure: oInstrReady only while buffered + in-flight < 2, so nothing is ever dropped; held stable under !iReady.
module operand_fetch
  import lab_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int OPC_WIDTH  = OPC_WIDTH_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iInstrValid,
  output logic                  oInstrReady,
  input  logic [OPC_WIDTH-1:0]  iOpcode,
  input  logic [ADDR_WIDTH-1:0] iDest,
  input  logic [ADDR_WIDTH-1:0] iSrc0,
  input  logic [ADDR_WIDTH-1:0] iSrc1,
  output logic [ADDR_WIDTH-1:0] oReadAddress0,
  output logic [ADDR_WIDTH-1:0] oReadAddress1,
  input  logic [DATA_WIDTH-1:0] iRamData0,
  input  logic [DATA_WIDTH-1:0] iRamData1,
  input  logic                  iWbEnable,
  input  logic [ADDR_WIDTH-1:0] iWbAddress,
  input  logic [DATA_WIDTH-1:0] iWbData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [OPC_WIDTH-1:0]  oOpcode,
  output logic [ADDR_WIDTH-1:0] oDest,
  output logic [DATA_WIDTH-1:0] oOperand0,
  output logic [DATA_WIDTH-1:0] oOperand1
);

  logic                  accept;
  logic                  if_vld;
  logic [OPC_WIDTH-1:0]  if_opc;
  logic [ADDR_WIDTH-1:0] if_dest;
  logic [DATA_WIDTH-1:0] cap_op0;
  logic [DATA_WIDTH-1:0] cap_op1;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  head_vld;
  logic [OPC_WIDTH-1:0]  head_opc;
  logic [ADDR_WIDTH-1:0] head_dest;
  logic [DATA_WIDTH-1:0] head_op0;
  logic [DATA_WIDTH-1:0] head_op1;

  // Room exists when the buffer can absorb everything already in flight plus one more.
  assign oInstrReady   = !Reset && !fifo_full && !(if_vld && !fifo_empty);
  assign accept        = iInstrValid && oInstrReady;
  assign oReadAddress0 = accept ? iSrc0 : '0;
  assign oReadAddress1 = accept ? iSrc1 : '0;

`ifdef OPERAND_FETCH_BYPASS_EN
  logic [ADDR_WIDTH-1:0] if_src0;
  logic [ADDR_WIDTH-1:0] if_src1;

  // Source addresses follow the instruction so later writebacks can be snooped.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if_src0 <= '0;
      if_src1 <= '0;
    end else if (accept) begin
      if_src0 <= iSrc0;
      if_src1 <= iSrc1;
    end
  end

  // A write landing in the capture cycle is newer than what the RAM returned.
  assign cap_op0 = (iWbEnable && (iWbAddress == if_src0)) ? iWbData : iRamData0;
  assign cap_op1 = (iWbEnable && (iWbAddress == if_src1)) ? iWbData : iRamData1;
`else
  logic unused_wb;
  assign unused_wb = ^{iWbEnable, iWbAddress, iWbData};
  assign cap_op0   = iRamData0;
  assign cap_op1   = iRamData1;
`endif

  // In-flight stage: holds the instruction while its RAM read completes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if_vld  <= 1'b0;
      if_opc  <= '0;
      if_dest <= '0;
    end else begin
      if_vld <= accept;
      if (accept) begin
        if_opc  <= iOpcode;
        if_dest <= iDest;
      end
    end
  end

  operand_fetch_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .OPC_WIDTH  (OPC_WIDTH)
  ) u_fifo (
    .Clock      (Clock),
    .Reset      (Reset),
    .push       (if_vld),
    .push_opc   (if_opc),
    .push_dest  (if_dest),
    .push_op0   (cap_op0),
    .push_op1   (cap_op1),
`ifdef OPERAND_FETCH_BYPASS_EN
    .push_src0  (if_src0),
    .push_src1  (if_src1),
    .snoop_vld  (iWbEnable),
    .snoop_addr (iWbAddress),
    .snoop_dat  (iWbData),
`endif
    .pop        (oValid && iReady),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_vld   (head_vld),
    .head_opc   (head_opc),
    .head_dest  (head_dest),
    .head_op0   (head_op0),
    .head_op1   (head_op1)
  );

  // Outputs are forced to zero while reset is held or nothing is available.
  assign oValid    = head_vld && !Reset;
  assign oOpcode   = oValid ? head_opc  : '0;
  assign oDest     = oValid ? head_dest : '0;
  assign oOperand0 = oValid ? head_op0  : '0;
  assign oOperand1 = oValid ? head_op1  : '0;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 16, register/operand width; SHALL match the register RAM.
REQ-002 Parameter ADDR_WIDTH, default 8, register address width.
REQ-003 Parameter OPC_WIDTH, default 6, opcode width.
REQ-004 Clock  in  1  single clock; all state on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 iInstrValid  in  1  upstream (decode) instruction valid.
REQ-007 oInstrReady  out  1  stage can accept an instruction this cycle.
REQ-008 iOpcode / iDest / iSrc0 / iSrc1  in  OPC_WIDTH / ADDR_WIDTH / ADDR_WIDTH / ADDR_WIDTH  instruction fields.
REQ-009 oReadAddress0 / oReadAddress1  out  ADDR_WIDTH  read addresses to the register RAM.
REQ-010 iRamData0 / iRamData1  in  DATA_WIDTH  registered RAM read data, valid one cycle after address issue.
REQ-011 iWbEnable / iWbAddress / iWbData  in  1 / ADDR_WIDTH / DATA_WIDTH  writeback port, same signals driving the RAM write port.
REQ-012 oValid  out  1  fetched instruction with operands available.
REQ-013 iReady  in  1  downstream (execute) accepts.
REQ-014 oOpcode / oDest / oOperand0 / oOperand1  out  OPC_WIDTH / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH  fetched instruction.

Function
REQ-015 Accept SHALL occur in cycle N when iInstrValid && oInstrReady; oReadAddressX SHALL equal iSrcX combinationally in that cycle (0 when no accept).
REQ-016 In N+1 the stage SHALL capture iRamData0/1 with the registered opcode/dest into a 2-entry output FIFO (in-flight stage -> FIFO).
REQ-017 RAM contract: data returned in N+1 SHALL include a write to the same address in cycle N (write-first).
REQ-018 oInstrReady SHALL be high iff (FIFO occupancy + in-flight count) < 2 and Reset is low; no entry is ever dropped.
REQ-019 oValid SHALL equal FIFO non-empty; outputs SHALL show the FIFO head; pop on oValid && iReady.
REQ-020 Push and pop in the same cycle SHALL leave occupancy unchanged; full throughput is one instruction per cycle with iReady held high.
REQ-021 Minimum latency: accept in N -> oValid in N+1 (capture is combinationally visible via FIFO bypass when empty), registered FIFO output thereafter.
REQ-022 Outputs SHALL be stable while oValid && !iReady.
REQ-023 Src0 == Src1 SHALL yield identical operands; address 0 has no special meaning.

Reset
REQ-024 Reset SHALL empty the FIFO, clear the in-flight stage, drive oValid=0, oInstrReady=0, oOpcode/oDest/oOperand0/oOperand1=0, oReadAddressX=0.
REQ-025 Reset mid-operation SHALL discard all in-flight and buffered instructions; oInstrReady SHALL rise in the first cycle after Reset deasserts.

Configuration
REQ-026 Macro OPERAND_FETCH_BYPASS_EN defined: the in-flight stage and every FIFO entry SHALL replace an operand with iWbData when iWbEnable and iWbAddress equals that operand's source address (write in N+1 or later).
REQ-027 Macro undefined: no snooping; operands SHALL reflect RAM data as read; source addresses need not be stored.

Structure
REQ-028 Shared package lab_cpu_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH/OPC_WIDTH defaults and opcode constants.
REQ-029 The 2-entry buffer SHALL be sub-module operand_fetch_fifo2 (push/pop, full/empty, per-entry snoop port).

Verification
REQ-030 Reset, then R3=0x1234, R5=0x00FF preloaded; issue opc=2, src0=3, src1=5, dest=7 with iReady=1 -> oValid in next cycle, operands 0x1234/0x00FF, dest 7.
REQ-031 Back-to-back 4 instructions, iReady=0 -> oInstrReady low after 2 accepts; release iReady -> all 4 delivered in order, none lost or duplicated.
REQ-032 (BYPASS_EN) Instr src0=3 accepted in N; write R3=0xBEEF in N+1 -> oOperand0=0xBEEF; write in N -> 0xBEEF via RAM.
REQ-033 (BYPASS_EN) Entry stalled in FIFO, write R5=0xAAAA while held -> oOperand1 changes to 0xAAAA before pop; without macro stays old value.
REQ-034 Reset asserted with 2 entries buffered -> oValid=0 next cycle; after release no stale entry appears, oInstrReady=1.
